// File: rtl/reu_regs.sv
// REU CPU-side register block: IO2 register file, command/execute handshake,
// live address and length counters with autoload shadows, status flags and IRQ.
module reu_regs #(
    parameter int REU_ABITS = 19
) (
    input  logic                 PHI2,
    input  logic                 RESET,
    input  logic                 nIO2,
    input  logic                 RnW,
    input  logic [4:0]           A,
    input  logic [7:0]           Din,
    output logic [7:0]           Dout,
    output logic                 DOE,
    input  logic                 FF00Hit,
    input  logic                 DMA,
    input  logic                 NextCA,
    input  logic                 NextREUA,
    input  logic                 XferEnd,
    input  logic                 VerifyErr,
    output logic                 Execute,
    output logic [1:0]           XferType,
    output logic                 Length1,
    output logic [15:0]          CA,
    output logic [REU_ABITS-1:0] REUA,
    output logic                 nIRQ,
    output logic [1:0]           exec_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRE  = 2'd2,
        S_BUSY  = 2'd3
    } exec_t;

    localparam logic                 SIZE_BIT = (REU_ABITS > 17) ? 1'b1 : 1'b0;
    localparam logic [REU_ABITS-1:0] REUA_ONE = 1;

    exec_t                state, state_nx;
    logic                 cmd_exec, cmd_auto, cmd_ff00dis;
    logic [1:0]           cmd_type;
    logic                 eob, verr;
    logic [2:0]           mask;
    logic                 fix_ca, fix_reua;
    logic [15:0]          ca, ca_sh, len, len_sh;
    logic [REU_ABITS-1:0] reua, reua_sh;
    logic                 cpu_wr, cmd_wr, st_rd, fire_ack, irq;
    logic [7:0]           bank_rd;

    assign cpu_wr   = !nIO2 && !RnW && !DMA;
    assign cmd_wr   = cpu_wr && (A == 5'd1);
    assign st_rd    = !nIO2 && RnW && (A == 5'd0);
    // Execute is the request, DMA is the acknowledge: Execute stays high until
    // DMA is sampled high on a falling edge, and drops on that same edge.
    assign fire_ack = (state == S_FIRE) && DMA;

    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_wr && Din[7]) state_nx = Din[4] ? S_FIRE : S_ARMED;
            S_ARMED: begin
                if (FF00Hit)                state_nx = S_FIRE;
                else if (cmd_wr && !Din[7]) state_nx = S_IDLE;
            end
            S_FIRE:  if (DMA)  state_nx = S_BUSY;
            S_BUSY:  if (!DMA) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            cmd_exec    <= 1'b0;
            cmd_auto    <= 1'b0;
            cmd_ff00dis <= 1'b1;
            cmd_type    <= 2'b00;
            eob         <= 1'b0;
            verr        <= 1'b0;
            mask        <= 3'b000;
            fix_ca      <= 1'b0;
            fix_reua    <= 1'b0;
        end else begin
            eob  <= XferEnd   || (eob  && !st_rd);
            verr <= VerifyErr || (verr && !st_rd);
            if (cmd_wr) begin
                cmd_exec    <= Din[7];
                cmd_auto    <= Din[5];
                cmd_ff00dis <= Din[4];
                cmd_type    <= Din[1:0];
            end else if (fire_ack) begin
                cmd_exec <= 1'b0;
            end
            if (cpu_wr && (A == 5'd9))  mask <= Din[7:5];
            if (cpu_wr && (A == 5'd10)) begin
                fix_ca   <= Din[7];
                fix_reua <= Din[6];
            end
        end
    end

    // CPU byte writes come last so they override any counter update on the same edge.
    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            ca      <= 16'h0000;
            ca_sh   <= 16'h0000;
            reua    <= '0;
            reua_sh <= '0;
            len     <= 16'hFFFF;
            len_sh  <= 16'hFFFF;
        end else begin
            if (XferEnd && cmd_auto) begin
                ca   <= ca_sh;
                reua <= reua_sh;
                len  <= len_sh;
            end else begin
                if (NextCA) begin
                    if (!fix_ca)  ca  <= ca + 16'd1;
                    if (!XferEnd) len <= len - 16'd1;
                end
                if (NextREUA && !fix_reua) reua <= reua + REUA_ONE;
            end
            if (cpu_wr) begin
                case (A)
                    5'd2: begin ca[7:0]    <= Din; ca_sh[7:0]    <= Din; end
                    5'd3: begin ca[15:8]   <= Din; ca_sh[15:8]   <= Din; end
                    5'd4: begin reua[7:0]  <= Din; reua_sh[7:0]  <= Din; end
                    5'd5: begin reua[15:8] <= Din; reua_sh[15:8] <= Din; end
                    5'd6: begin
                        reua[REU_ABITS-1:16]    <= Din[REU_ABITS-17:0];
                        reua_sh[REU_ABITS-1:16] <= Din[REU_ABITS-17:0];
                    end
                    5'd7: begin len[7:0]  <= Din; len_sh[7:0]  <= Din; end
                    5'd8: begin len[15:8] <= Din; len_sh[15:8] <= Din; end
                    default: ;
                endcase
            end
        end
    end

    assign irq = mask[2] && ((eob && mask[1]) || (verr && mask[0]));

    always_comb begin
        bank_rd                  = 8'hFF;
        bank_rd[REU_ABITS-17:0]  = reua[REU_ABITS-1:16];
        Dout                     = 8'hFF;
        case (A)
            5'd0:    Dout = {irq, eob, verr, SIZE_BIT, 4'b0000};
            5'd1:    Dout = {cmd_exec, 1'b1, cmd_auto, cmd_ff00dis, 2'b11, cmd_type};
            5'd2:    Dout = ca[7:0];
            5'd3:    Dout = ca[15:8];
            5'd4:    Dout = reua[7:0];
            5'd5:    Dout = reua[15:8];
            5'd6:    Dout = bank_rd;
            5'd7:    Dout = len[7:0];
            5'd8:    Dout = len[15:8];
            5'd9:    Dout = {mask, 5'b11111};
            5'd10:   Dout = {fix_ca, fix_reua, 6'b111111};
            default: Dout = 8'hFF;
        endcase
    end

    assign DOE        = !nIO2 && RnW && !DMA;
    assign Execute    = (state == S_FIRE);
    assign XferType   = cmd_type;
    assign Length1    = (len == 16'h0001);
    assign CA         = ca;
    assign REUA       = reua;
    assign nIRQ       = !irq;
    assign exec_state = state;

endmodule

// File: tb/tb_reu_regs.sv
// Bench for reu_regs: directed checks with literal expectations, then random
// bus/sequencer traffic compared every cycle against a behavioural model.
module tb_reu_regs;

    localparam int ABITS = 19;

    logic             PHI2 = 1'b1;
    logic             RESET = 1'b1;
    logic             nIO2 = 1'b1, RnW = 1'b1;
    logic [4:0]       A = '0;
    logic [7:0]       Din = '0;
    logic [7:0]       Dout;
    logic             DOE;
    logic             FF00Hit = 1'b0, DMA = 1'b0, NextCA = 1'b0, NextREUA = 1'b0;
    logic             XferEnd = 1'b0, VerifyErr = 1'b0;
    logic             Execute, Length1, nIRQ;
    logic [1:0]       XferType, exec_state;
    logic [15:0]      CA;
    logic [ABITS-1:0] REUA;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;
    logic [23:0] exp_q[$];

    reu_regs #(.REU_ABITS(ABITS)) dut (
        .PHI2(PHI2), .RESET(RESET), .nIO2(nIO2), .RnW(RnW), .A(A), .Din(Din),
        .Dout(Dout), .DOE(DOE), .FF00Hit(FF00Hit), .DMA(DMA), .NextCA(NextCA),
        .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr),
        .Execute(Execute), .XferType(XferType), .Length1(Length1), .CA(CA),
        .REUA(REUA), .nIRQ(nIRQ), .exec_state(exec_state)
    );

    // clock / reset
    always #5 PHI2 = ~PHI2;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural model: register contents as plain numbers, execute as three flags
    int  m_ca, m_ca_sh, m_reua, m_reua_sh, m_len, m_len_sh;
    int  m_cmd, m_mask, m_actl;
    bit  m_eob, m_verr, m_armed, m_fire, m_busy;

    task automatic model_reset();
        m_ca = 0; m_ca_sh = 0; m_reua = 0; m_reua_sh = 0;
        m_len = 'hFFFF; m_len_sh = 'hFFFF;
        m_cmd = 'h10; m_mask = 0; m_actl = 0;
        m_eob = 0; m_verr = 0; m_armed = 0; m_fire = 0; m_busy = 0;
    endtask

    task automatic model_step();
        bit wr, rd0, autold, fca, fra;
        int d, a;
        d = Din; a = A;
        wr = !nIO2 && !RnW && !DMA;
        rd0 = !nIO2 && RnW && (a == 0);
        autold = (m_cmd & 'h20) != 0;
        fca = (m_actl & 'h80) != 0;
        fra = (m_actl & 'h40) != 0;
        if (m_fire) begin
            if (DMA) begin m_fire = 0; m_busy = 1; m_cmd = m_cmd & 'h7F; end
        end else if (m_busy) begin
            if (!DMA) m_busy = 0;
        end else if (m_armed) begin
            if (FF00Hit) begin m_armed = 0; m_fire = 1; end
            else if (wr && a == 1 && d < 'h80) m_armed = 0;
        end else if (wr && a == 1 && d >= 'h80) begin
            if ((d & 'h10) != 0) m_fire = 1; else m_armed = 1;
        end
        if (XferEnd && autold) begin
            m_ca = m_ca_sh; m_reua = m_reua_sh; m_len = m_len_sh;
        end else begin
            if (NextCA) begin
                if (!fca) m_ca = (m_ca + 1) % 65536;
                if (!XferEnd) m_len = (m_len + 65535) % 65536;
            end
            if (NextREUA && !fra) m_reua = (m_reua + 1) % (1 << ABITS);
        end
        m_eob  = XferEnd   || (m_eob  && !rd0);
        m_verr = VerifyErr || (m_verr && !rd0);
        if (wr) begin
            case (a)
                1: m_cmd = d;
                2: begin m_ca = (m_ca & 'hFF00) | d; m_ca_sh = (m_ca_sh & 'hFF00) | d; end
                3: begin m_ca = (m_ca & 'hFF) | (d << 8); m_ca_sh = (m_ca_sh & 'hFF) | (d << 8); end
                4: begin m_reua = (m_reua & ~'hFF) | d; m_reua_sh = (m_reua_sh & ~'hFF) | d; end
                5: begin
                    m_reua = (m_reua & ~'hFF00) | (d << 8);
                    m_reua_sh = (m_reua_sh & ~'hFF00) | (d << 8);
                end
                6: begin
                    m_reua = (m_reua & 'hFFFF) | ((d << 16) % (1 << ABITS));
                    m_reua_sh = (m_reua_sh & 'hFFFF) | ((d << 16) % (1 << ABITS));
                end
                7: begin m_len = (m_len & 'hFF00) | d; m_len_sh = (m_len_sh & 'hFF00) | d; end
                8: begin m_len = (m_len & 'hFF) | (d << 8); m_len_sh = (m_len_sh & 'hFF) | (d << 8); end
                9: m_mask = d & 'hE0;
                10: m_actl = d & 'hC0;
                default: ;
            endcase
        end
    endtask

    function automatic bit model_irq();
        return ((m_mask & 'h80) != 0) &&
               ((m_eob && (m_mask & 'h40) != 0) || (m_verr && (m_mask & 'h20) != 0));
    endfunction

    function automatic int model_rd(input int a);
        case (a)
            0: return (int'(model_irq()) << 7) | (int'(m_eob) << 6) | (int'(m_verr) << 5) |
                      ((ABITS > 17) ? 'h10 : 0);
            1: return (m_cmd & 'hB3) | 'h4C;
            2: return m_ca & 'hFF;
            3: return m_ca >> 8;
            4: return m_reua & 'hFF;
            5: return (m_reua >> 8) & 'hFF;
            6: return ((m_reua >> 16) | ('hFF << (ABITS - 16))) & 'hFF;
            7: return m_len & 'hFF;
            8: return m_len >> 8;
            9: return m_mask | 'h1F;
            10: return m_actl | 'h3F;
            default: return 'hFF;
        endcase
    endfunction

    always @(negedge PHI2 or posedge RESET) begin
        if (RESET) model_reset();
        else       model_step();
    end

    // compare process: outputs are stable between falling edges
    always @(posedge PHI2) begin
        #4;
        if (run_cmp && !RESET) begin
            check("dout",     Dout,     model_rd(A));
            check("doe",      DOE,      int'(!nIO2 && RnW && !DMA));
            check("execute",  Execute,  int'(m_fire));
            check("xfertype", XferType, m_cmd & 3);
            check("length1",  Length1,  int'(m_len == 1));
            check("ca",       CA,       m_ca);
            check("reua",     REUA,     m_reua);
            check("nirq",     nIRQ,     int'(!model_irq()));
        end
    end

    // driver tasks
    task automatic drive(input bit nio2, input bit rnw, input int a, input int d, input bit dma,
                         input bit nca, input bit nra, input bit xe, input bit ve, input bit ff);
        @(posedge PHI2);
        #1;
        nIO2 = nio2; RnW = rnw; A = a[4:0]; Din = d[7:0]; DMA = dma;
        NextCA = nca; NextREUA = nra; XferEnd = xe; VerifyErr = ve; FF00Hit = ff;
    endtask

    task automatic idle();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        drive(0, 0, a, d, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek(input int a, input int exp, input string name);
        drive(0, 1, a, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(exp[23:0]);
        #3;
        check(name, Dout, int'(exp_q.pop_front()));
    endtask

    task automatic pin(input string name, input int act, input int exp);
        exp_q.push_back(exp[23:0]);
        check(name, act, int'(exp_q.pop_front()));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge PHI2);
        #1 RESET = 1'b0;
        run_cmp = 1'b1;
        #3;
        pin("rst_nirq", nIRQ, 1);
        pin("rst_exec", Execute, 0);
        peek(0, 'h10, "rst_status");
        peek(1, 'h5C, "rst_cmd");
        peek(7, 'hFF, "rst_len_lo");
        peek(8, 'hFF, "rst_len_hi");
        peek(11, 'hFF, "rd_0b");
        peek(6, 'hF8, "rst_bank");

        // immediate execute
        wr(1, 'h90);
        idle(); #3 pin("exec_fire", Execute, 1);
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0); #3 pin("exec_held", Execute, 1);
        peek(1, 'h5C, "cmd_exec_clr");
        pin("exec_drop", Execute, 0);

        // armed until $FF00 write
        wr(1, 'h80);
        for (int i = 0; i < 5; i++) begin idle(); #3 pin("armed_wait", Execute, 0); end
        peek(1, 'hCC, "cmd_armed");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); #3 pin("ff00_edge", Execute, 0);
        idle(); #3 pin("ff00_fire", Execute, 1);
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(); #3 pin("ff00_done", Execute, 0);

        // autoload
        wr(2, 'h00); wr(3, 'h10); wr(7, 'h02); wr(8, 'h00); wr(1, 'h20);
        drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        idle(); #3 pin("auto_ca", CA, 'h1000);
        pin("auto_len1", Length1, 0);
        peek(7, 'h02, "auto_len_lo");
        peek(0, 'h50, "eob_status");
        peek(0, 'h10, "eob_cleared");

        // no autoload: length sticks at 1
        wr(1, 'h00);
        drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        idle(); #3 pin("noauto_ca", CA, 'h1002);
        pin("noauto_len1", Length1, 1);
        peek(7, 'h01, "noauto_len_lo");
        peek(0, 'h50, "noauto_eob");

        // REU address wrap and fix
        wr(4, 'hFF); wr(5, 'hFF); wr(6, 'h07);
        idle(); #3 pin("reua_max", REUA, 'h7FFFF);
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        idle(); #3 pin("reua_wrap", REUA, 0);
        peek(6, 'hF8, "bank_wrap");
        wr(10, 'h40); wr(4, 'h34); wr(5, 'h12); wr(6, 'h05);
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        idle(); #3 pin("reua_fixed", REUA, 'h51234);
        peek(6, 'hFD, "bank_rd");
        peek(10, 'h7F, "actl_rd");
        wr(10, 'h00);

        // verify-error IRQ and read-clear
        wr(9, 'hE0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); #3 pin("verr_nirq", nIRQ, 0);
        peek(0, 'hB0, "verr_status");
        idle(); #3 pin("verr_nirq_clr", nIRQ, 1);
        peek(0, 'h10, "verr_cleared");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0); #3 pin("verr_coinc_rd", Dout, 'hB0);
        peek(0, 'hB0, "verr_set_wins");
        peek(0, 'h10, "verr_cleared2");

        // end-of-block IRQ
        wr(9, 'hC0);
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(); #3 pin("eob_nirq", nIRQ, 0);
        peek(0, 'hD0, "eob_irq_status");
        peek(0, 'h10, "eob_irq_cleared");

        // reset while Execute is up
        wr(2, 'h55); wr(1, 'h90);
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        #1 RESET = 1'b1;
        #2;
        pin("rst_mid_exec", Execute, 0);
        pin("rst_mid_ca", CA, 0);
        pin("rst_mid_nirq", nIRQ, 1);
        @(posedge PHI2);
        #1 RESET = 1'b0;
        peek(1, 'h5C, "rst_mid_cmd");
        peek(7, 'hFF, "rst_mid_len");

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 15) == 0);
        end
        idle();
        idle();
        #3 run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
